// File: rtl/cv_tile_scheduler.sv
// rtl/cv_tile_scheduler.sv - layer-level conv tile sequencer driving the CV data loader
//
// Walks one conv layer in tiles (O-tile, h-tile, w-tile, I-tile, outermost first)
// and issues load_weight / load_input / store_output one at a time, each closed by
// the loader's done pulse and followed by exactly one command-free gap cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle layer start pulse, ignored while busy
//   I, O, H, W, K              layer dims (K 5 bits), sampled at start
//   TI, TO, TH, TW             tile sizes, sampled at start, 0 treated as 1
//   busy, layer_done           layer in flight / one-cycle end-of-layer pulse
//   Iori, Oori, Hori, Wori     tile origin (H/W in output coordinates)
//   Iext, Oext, Hext, Wext     tile extents (Hext/Wext are input extents)
//   load_weight, load_input,
//   store_output               loader commands, at most one high
//   done                       loader completion pulse
//   perf_cycles, perf_cmds     present only when CV_TILE_PERF_EN is defined
//
// Optional feature macro: CV_TILE_PERF_EN (busy-cycle and completed-command counters).

module cv_tile_scheduler #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] I,
    input  logic [DW-1:0] O,
    input  logic [DW-1:0] H,
    input  logic [DW-1:0] W,
    input  logic [4:0]    K,
    input  logic [DW-1:0] TI,
    input  logic [DW-1:0] TO,
    input  logic [DW-1:0] TH,
    input  logic [DW-1:0] TW,
    output logic          busy,
    output logic          layer_done,
    output logic [DW-1:0] Iori,
    output logic [DW-1:0] Oori,
    output logic [DW-1:0] Hori,
    output logic [DW-1:0] Wori,
    output logic [DW-1:0] Iext,
    output logic [DW-1:0] Oext,
    output logic [DW-1:0] Hext,
    output logic [DW-1:0] Wext,
    output logic          load_weight,
    output logic          load_input,
    output logic          store_output,
`ifdef CV_TILE_PERF_EN
    output logic [31:0]   perf_cycles,
    output logic [15:0]   perf_cmds,
`endif
    input  logic          done
);

    typedef enum logic [2:0] {S_IDLE, S_LW, S_LIF, S_SOF, S_GAP, S_FIN} state_t;

    state_t state, ret_state, n_state;

    // Latched layer parameters
    logic [DW-1:0] i_r, o_r, ti_r, to_r, th_r, tw_r;
    logic [4:0]    k_r;
    logic [DW:0]   hout_r, wout_r;

    // Input-side values used on the start cycle (before anything is latched)
    logic [DW-1:0] ti_s, to_s, th_s, tw_s;
    logic [DW:0]   hout_s, wout_s;
    logic          degen;

    assign ti_s   = (TI == '0) ? DW'(1) : TI;
    assign to_s   = (TO == '0) ? DW'(1) : TO;
    assign th_s   = (TH == '0) ? DW'(1) : TH;
    assign tw_s   = (TW == '0) ? DW'(1) : TW;
    assign hout_s = {1'b0, H} - {{(DW-4){1'b0}}, K} + (DW+1)'(1);
    assign wout_s = {1'b0, W} - {{(DW-4){1'b0}}, K} + (DW+1)'(1);

    // Output dims are a signed quantity: top bit set means K > H (or W) + 1
    assign degen = (O == '0) || (I == '0) ||
                   hout_s[DW] || (hout_s == '0) ||
                   wout_s[DW] || (wout_s == '0);

    // Parameter source: live inputs while idle, latched copies while busy
    logic          idle;
    logic [DW-1:0] p_i, p_o, p_ti, p_to, p_th, p_tw;
    logic [4:0]    p_k;
    logic [DW:0]   p_hout, p_wout;

    assign idle   = (state == S_IDLE);
    assign p_i    = idle ? I      : i_r;
    assign p_o    = idle ? O      : o_r;
    assign p_ti   = idle ? ti_s   : ti_r;
    assign p_to   = idle ? to_s   : to_r;
    assign p_th   = idle ? th_s   : th_r;
    assign p_tw   = idle ? tw_s   : tw_r;
    assign p_k    = idle ? K      : k_r;
    assign p_hout = idle ? hout_s : hout_r;
    assign p_wout = idle ? wout_s : wout_r;

    // Next tile origin and the command to issue after the gap
    logic [DW-1:0] n_iori, n_oori, n_hori, n_wori;
    logic [DW:0]   isum, wsum, hsum, osum;

    always_comb begin
        n_iori  = Iori;
        n_oori  = Oori;
        n_hori  = Hori;
        n_wori  = Wori;
        n_state = state;
        isum    = {1'b0, Iori} + {1'b0, Iext};
        wsum    = {1'b0, Wori} + {1'b0, p_tw};
        hsum    = {1'b0, Hori} + {1'b0, p_th};
        osum    = {1'b0, Oori} + {1'b0, p_to};
        case (state)
            S_IDLE: begin
                n_iori  = '0;
                n_oori  = '0;
                n_hori  = '0;
                n_wori  = '0;
                n_state = degen ? S_FIN : S_LW;
            end
            S_LW:  n_state = S_LIF;
            S_LIF: begin
                if (isum < {1'b0, p_i}) begin
                    n_iori  = isum[DW-1:0];
                    n_state = S_LIF;
                end else begin
                    n_state = S_SOF;
                end
            end
            S_SOF: begin
                n_iori  = '0;
                n_state = S_LIF;
                if (wsum < p_wout) begin
                    n_wori = wsum[DW-1:0];
                end else begin
                    n_wori = '0;
                    if (hsum < p_hout) begin
                        n_hori = hsum[DW-1:0];
                    end else begin
                        n_hori = '0;
                        if (osum < {1'b0, p_o}) begin
                            n_oori  = osum[DW-1:0];
                            n_state = S_LW;
                        end else begin
                            n_state = S_FIN;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Extents for the next origin, registered alongside it
    logic [DW-1:0] o_rem, i_rem, n_oext, n_iext, n_hext, n_wext;
    logic [DW:0]   h_rem, w_rem, h_min, w_min;

    always_comb begin
        o_rem  = p_o - n_oori;
        i_rem  = p_i - n_iori;
        n_oext = (p_to < o_rem) ? p_to : o_rem;
        n_iext = (p_ti < i_rem) ? p_ti : i_rem;
        h_rem  = p_hout - {1'b0, n_hori};
        w_rem  = p_wout - {1'b0, n_wori};
        h_min  = ({1'b0, p_th} < h_rem) ? {1'b0, p_th} : h_rem;
        w_min  = ({1'b0, p_tw} < w_rem) ? {1'b0, p_tw} : w_rem;
        n_hext = DW'(h_min + {{(DW-4){1'b0}}, p_k} - (DW+1)'(1));
        n_wext = DW'(w_min + {{(DW-4){1'b0}}, p_k} - (DW+1)'(1));
    end

    logic cmd_active;
    assign cmd_active = (state == S_LW) || (state == S_LIF) || (state == S_SOF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ret_state  <= S_IDLE;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            Iori <= '0; Oori <= '0; Hori <= '0; Wori <= '0;
            Iext <= '0; Oext <= '0; Hext <= '0; Wext <= '0;
            i_r  <= '0; o_r  <= '0; ti_r <= '0; to_r <= '0;
            th_r <= '0; tw_r <= '0; k_r  <= '0;
            hout_r <= '0; wout_r <= '0;
        end else begin
            layer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i_r    <= I;
                        o_r    <= O;
                        ti_r   <= ti_s;
                        to_r   <= to_s;
                        th_r   <= th_s;
                        tw_r   <= tw_s;
                        k_r    <= K;
                        hout_r <= hout_s;
                        wout_r <= wout_s;
                        busy   <= 1'b1;
                        Iori <= '0; Oori <= '0; Hori <= '0; Wori <= '0;
                        if (!degen) begin
                            Iext <= n_iext; Oext <= n_oext;
                            Hext <= n_hext; Wext <= n_wext;
                        end
                        state <= n_state;
                    end
                end
                S_LW, S_LIF, S_SOF: begin
                    // Tile counters advance on entry to the gap cycle
                    if (done) begin
                        Iori <= n_iori; Oori <= n_oori;
                        Hori <= n_hori; Wori <= n_wori;
                        if (n_state != S_FIN) begin
                            Iext <= n_iext; Oext <= n_oext;
                            Hext <= n_hext; Wext <= n_wext;
                        end
                        ret_state <= n_state;
                        state     <= S_GAP;
                    end
                end
                S_GAP: state <= ret_state;
                S_FIN: begin
                    layer_done <= 1'b1;
                    busy       <= 1'b0;
                    Iori <= '0; Oori <= '0; Hori <= '0; Wori <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign load_weight  = (state == S_LW);
    assign load_input   = (state == S_LIF);
    assign store_output = (state == S_SOF);

`ifdef CV_TILE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_cmds   <= '0;
        end else if (idle && start) begin
            perf_cycles <= '0;
            perf_cmds   <= '0;
        end else begin
            if (busy && (perf_cycles != '1))
                perf_cycles <= perf_cycles + 32'd1;
            if (cmd_active && done && (perf_cmds != '1))
                perf_cmds <= perf_cmds + 16'd1;
        end
    end
`endif

endmodule
